// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB initiator bridge.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready load-store request to APB3 initiator, one outstanding transfer.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              aligned;

  assign aligned = ((req_addr[1:0] & APB_ALIGN_MASK) == 2'b00);

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             timeout_hit;

  // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle without PREADY.
  assign timeout_hit = (state_q == ACCESS) && !PREADY &&
                       (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q == IDLE && state_d == SETUP) begin
      to_cnt_q <= '0;
    end else if (state_q == ACCESS && !PREADY) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_vld) begin
          if (aligned) begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            pwrite_d = req_we;
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
          end else begin
            state_d     = RESP;
            rsp_vld_d   = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end
`ifdef APB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
`endif
      end
      RESP: begin
        if (rsp_rdy) begin
          state_d   = IDLE;
          rsp_vld_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        rsp_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_rdy   = (state_q == IDLE);
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed table, hand sequences, random traffic.
module tb_apb_master_bridge;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TO    = 4;
  localparam int LIMIT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_vld, req_rdy, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_vld, rsp_rdy, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          slverr;
    logic [DW-1:0] prdata;
    int            rsp_delay;
    logic          hold_req;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome of one request given the completer's behaviour.
  function automatic void model(input logic we, input logic [AW-1:0] addr, input int waits,
                                input logic slverr, input logic [DW-1:0] prdata,
                                output logic err, output logic [DW-1:0] rdata,
                                output int lat, output int acc);
    logic timed_out;
    timed_out = 1'b0;
    if (addr % 4 != 0) begin
      err = 1'b1; rdata = '0; lat = 1; acc = 0;
    end else begin
      acc = waits + 1;
`ifdef APB_TIMEOUT_EN
      if (waits >= TO) begin
        acc = TO;
        timed_out = 1'b1;
      end
`endif
      err   = timed_out ? 1'b1 : slverr;
      rdata = (!we && !err) ? prdata : '0;
      lat   = 2 + acc;
    end
  endfunction

  // Starts and ends at a falling edge; completer behaviour is modelled inline.
  task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic slverr, input logic [DW-1:0] prdata,
                        input int rsp_delay, input logic hold_req,
                        input logic exp_err, input logic [DW-1:0] exp_rdata, input int exp_lat);
    int            cyc, setup_n, acc_n, m_lat, m_acc;
    logic          m_err, got, stable_ok;
    logic [DW-1:0] m_rd;
    model(we, addr, waits, slverr, prdata, m_err, m_rd, m_lat, m_acc);
    req_vld = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    chk("req_rdy_idle", 64'(req_rdy), 64'd1);
    got = 1'b0; stable_ok = 1'b1; setup_n = 0; acc_n = 0; cyc = 0;
    while (!got && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      req_vld = 1'b0;
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
      if (rsp_vld) begin
        got = 1'b1;
      end else if (PSEL) begin
        if (PADDR !== addr || PWRITE !== we || PWDATA !== wdata) stable_ok = 1'b0;
        if (!PENABLE) begin
          setup_n++;
        end else begin
          acc_n++;
          PREADY = (acc_n == waits + 1);
          if (PREADY) begin
            PSLVERR = slverr;
            PRDATA  = prdata;
          end
        end
      end
    end
    PREADY = 1'b0;
    chk("rsp_arrived", 64'(got), 64'd1);
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("setup_cycles", 64'(setup_n), (m_acc > 0) ? 64'd1 : 64'd0);
    chk("access_cycles", 64'(acc_n), 64'(m_acc));
    chk("apb_stable", 64'(stable_ok), 64'd1);
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    for (int i = 0; i < rsp_delay; i++) begin
      if (hold_req) begin
        req_vld = 1'b1; req_addr = addr + 32'h100; req_we = ~we;
      end
      @(negedge clk);
      chk("rsp_hold_vld", 64'(rsp_vld), 64'd1);
      chk("rsp_hold_data", 64'({rsp_err, rsp_rdata}), 64'({exp_err, exp_rdata}));
      chk("req_rdy_busy", 64'(req_rdy), 64'd0);
      chk("psel_busy", 64'(PSEL), 64'd0);
    end
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("rsp_drop", 64'(rsp_vld), 64'd0);
    chk("req_rdy_back", 64'(req_rdy), 64'd1);
  endtask

  initial begin
    vec_t          vt[7];
    logic          m_err;
    logic [DW-1:0] m_rd;
    int            m_lat, m_acc;

    vt[0] = '{1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_5555, 0, 1'b0, 1'b0, 32'h0, 3};
    vt[0].we = 1'b1;
    vt[1] = '{1'b0, 32'h1000_0008, 32'h0, 3, 1'b0, 32'h0000_00A5, 0, 1'b0, 1'b0, 32'h0000_00A5, 6};
    vt[2] = '{1'b0, 32'h1000_000C, 32'h0, 1, 1'b1, 32'h1234_5678, 0, 1'b0, 1'b1, 32'h0, 4};
    vt[3] = '{1'b1, 32'h1000_0002, 32'h1111_2222, 0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 1};
    vt[4] = '{1'b0, 32'h2000_0000, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 5, 1'b1, 1'b0, 32'hCAFE_F00D, 3};
    vt[5] = '{1'b1, 32'h3000_0010, 32'hA5A5_0F0F, 2, 1'b1, 32'hFFFF_FFFF, 1, 1'b0, 1'b1, 32'h0, 5};
    vt[6] = '{1'b0, 32'h1000_0003, 32'h0, 0, 1'b0, 32'h0, 2, 1'b1, 1'b1, 32'h0, 1};

    rst = 1'b1; req_vld = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_rdy = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].waits, vt[i].slverr, vt[i].prdata,
             vt[i].rsp_delay, vt[i].hold_req, vt[i].exp_err, vt[i].exp_rdata, vt[i].exp_lat);
    end

    // Address/data must not toggle while idle after a completed write.
    repeat (2) @(negedge clk);
    chk("idle_paddr_hold", 64'(PADDR), 64'h1000_0010 + 64'h2000_0000);
    chk("idle_pwdata_hold", 64'(PWDATA), 64'hA5A5_0F0F);

    // Reset while in ACCESS abandons the transfer with no response.
    req_vld = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040; req_wdata = '0;
    PREADY = 1'b0;
    @(negedge clk);
    req_vld = 1'b0;
    @(negedge clk);
    chk("rstmid_in_access", 64'({PSEL, PENABLE}), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_psel", 64'(PSEL), 64'd0);
    chk("rstmid_penable", 64'(PENABLE), 64'd0);
    chk("rstmid_rsp_vld", 64'(rsp_vld), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_req_rdy", 64'(req_rdy), 64'd1);

`ifdef APB_TIMEOUT_EN
    do_txn(1'b0, 32'h1000_0020, 32'h0, 1000, 1'b0, 32'h0000_0077, 0, 1'b0, 1'b1, 32'h0, 2 + TO);
`endif

    for (int n = 0; n < 40; n++) begin
      logic          r_we, r_err;
      logic [AW-1:0] r_addr;
      logic [DW-1:0] r_wdata, r_prdata;
      int            r_waits;
      r_we     = 1'($urandom_range(0, 1));
      r_addr   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) r_addr = r_addr | 32'($urandom_range(1, 3));
      r_wdata  = $urandom;
      r_prdata = $urandom;
      r_waits  = $urandom_range(0, 6);
      r_err    = ($urandom_range(0, 4) == 0);
      model(r_we, r_addr, r_waits, r_err, r_prdata, m_err, m_rd, m_lat, m_acc);
      do_txn(r_we, r_addr, r_wdata, r_waits, r_err, r_prdata, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), m_err, m_rd, m_lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
